// File: rtl/word_byte_pkg.sv
// Shared definitions for the word-to-byte narrowing path.
// Holds the datapath/byte widths, the derived byte count per word and the
// mode and FSM state encodings used by word_byte_splitter.
package word_byte_pkg;

  localparam int unsigned WORD_W    = 20;
  localparam int unsigned BYTE_W    = 8;
  localparam int unsigned NUM_BYTES = (WORD_W + BYTE_W - 1) / BYTE_W;

  typedef enum logic {
    MODE_NARROW = 1'b0,
    MODE_SPLIT  = 1'b1
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_B0   = 2'd1,
    ST_B1   = 2'd2,
    ST_B2   = 2'd3
  } state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter for status/diagnostic counts.
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset, clears the count
//   inc    increment by one this cycle (ignored once saturated)
//   count  current count, sticks at all-ones
module sat_counter #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc && !(&count_q)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/word_byte_splitter.sv
// Returns datapath words to byte width for byte-wide consumers.
// NARROW mode emits the low byte with an overflow flag when the dropped upper
// bits are non-zero; SPLIT mode serialises the word LSB-first into 3 bytes.
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   in_word/in_mode      word and mode, taken on in_valid && in_ready
//   in_valid/in_ready    input handshake; in_ready only in IDLE
//   out_byte/out_last    current byte, final-byte marker
//   out_ovf              NARROW overflow flag (never set in SPLIT)
//   out_valid/out_ready  output handshake
//   ovf_count            saturating count of overflowing NARROW words
module word_byte_splitter
  import word_byte_pkg::*;
#(
  parameter int unsigned WORD_W = word_byte_pkg::WORD_W,
  parameter int unsigned BYTE_W = word_byte_pkg::BYTE_W,
  parameter int unsigned CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WORD_W-1:0] in_word,
  input  logic              in_mode,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [BYTE_W-1:0] out_byte,
  output logic              out_last,
  output logic              out_ovf,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  ovf_count
);

  state_e              state_q, state_d;
  mode_e               mode_q, mode_d;
  logic [WORD_W-1:0]   shift_q, shift_d;
  logic [BYTE_W-1:0]   byte_q, byte_d;
  logic                last_q, last_d;
  logic                ovf_q, ovf_d;
  logic                ovf_inc;
  logic                upper_nz;
  logic [WORD_W-1:0]   shifted;

  // Non-zero upper bits are what zero-extension could not have produced.
  assign upper_nz = |in_word[WORD_W-1:BYTE_W];
  // Shifting right zero-fills, which gives the padded top byte for free.
  assign shifted  = shift_q >> BYTE_W;

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    shift_d = shift_q;
    byte_d  = byte_q;
    last_d  = last_q;
    ovf_d   = ovf_q;
    ovf_inc = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          state_d = ST_B0;
          mode_d  = mode_e'(in_mode);
          shift_d = in_word;
          byte_d  = in_word[BYTE_W-1:0];
          if (mode_e'(in_mode) == MODE_NARROW) begin
            last_d  = 1'b1;
            ovf_d   = upper_nz;
            ovf_inc = upper_nz;
          end else begin
            last_d = 1'b0;
            ovf_d  = 1'b0;
          end
        end
      end
      ST_B0: begin
        if (out_ready) begin
          if (mode_q == MODE_NARROW) begin
            state_d = ST_IDLE;
            byte_d  = '0;
            last_d  = 1'b0;
            ovf_d   = 1'b0;
          end else begin
            state_d = ST_B1;
            shift_d = shifted;
            byte_d  = shifted[BYTE_W-1:0];
            last_d  = 1'b0;
          end
        end
      end
      ST_B1: begin
        if (out_ready) begin
          state_d = ST_B2;
          shift_d = shifted;
          byte_d  = shifted[BYTE_W-1:0];
          last_d  = 1'b1;
        end
      end
      ST_B2: begin
        if (out_ready) begin
          state_d = ST_IDLE;
          byte_d  = '0;
          last_d  = 1'b0;
          ovf_d   = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      mode_q  <= MODE_NARROW;
      shift_q <= '0;
      byte_q  <= '0;
      last_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      shift_q <= shift_d;
      byte_q  <= byte_d;
      last_q  <= last_d;
      ovf_q   <= ovf_d;
    end
  end

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_ovf_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (ovf_inc),
    .count (ovf_count)
  );

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q != ST_IDLE);
  assign out_byte  = byte_q;
  assign out_last  = last_q;
  assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_word_byte_splitter.sv
// Directed bench for word_byte_splitter: NARROW, SPLIT, backpressure,
// mid-word reset and overflow counter saturation.
module tb_word_byte_splitter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [19:0] in_word;
  logic        in_mode;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  out_byte;
  logic        out_last;
  logic        out_ovf;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  ovf_count;

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  word_byte_splitter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_word   (in_word),
    .in_mode   (in_mode),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_byte  (out_byte),
    .out_last  (out_last),
    .out_ovf   (out_ovf),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ovf_count (ovf_count)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; return at the following falling edge with outputs settled.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_out(input string tag, input logic [7:0] b, input logic last,
                           input logic ovf);
    check_eq({tag, "_valid"}, out_valid, 1'b1);
    check_eq({tag, "_byte"},  out_byte,  b);
    check_eq({tag, "_last"},  out_last,  last);
    check_eq({tag, "_ovf"},   out_ovf,   ovf);
  endtask

  // Present a word in IDLE and let it be accepted on the next edge.
  task automatic accept(input string tag, input logic [19:0] w, input logic m);
    check_eq({tag, "_in_ready"}, in_ready, 1'b1);
    in_word  = w;
    in_mode  = m;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    rst_n     = 1'b0;
    in_word   = '0;
    in_mode   = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    tick();
    rst_n = 1'b1;

    // Reset state
    check_eq("rst_out_valid", out_valid, 1'b0);
    check_eq("rst_out_byte",  out_byte,  8'h00);
    check_eq("rst_out_last",  out_last,  1'b0);
    check_eq("rst_out_ovf",   out_ovf,   1'b0);
    check_eq("rst_count",     ovf_count, 8'd0);
    check_eq("rst_in_ready",  in_ready,  1'b1);

    // NARROW without overflow
    accept("n17", 20'h00017, 1'b0);
    check_out("n17", 8'h17, 1'b1, 1'b0);
    check_eq("n17_in_ready_busy", in_ready, 1'b0);
    check_eq("n17_count", ovf_count, 8'd0);
    tick();
    check_eq("n17_done_valid", out_valid, 1'b0);
    check_eq("n17_done_in_ready", in_ready, 1'b1);

    // NARROW with overflow, then a clean one
    accept("nd8", 20'hFFFD8, 1'b0);
    check_out("nd8", 8'hD8, 1'b1, 1'b1);
    check_eq("nd8_count", ovf_count, 8'd1);
    tick();
    accept("n54", 20'h00054, 1'b0);
    check_out("n54", 8'h54, 1'b1, 1'b0);
    check_eq("n54_count", ovf_count, 8'd1);
    tick();

    // SPLIT full rate
    accept("sab", 20'hABCDE, 1'b1);
    check_out("sab_b0", 8'hDE, 1'b0, 1'b0);
    tick();
    check_out("sab_b1", 8'hBC, 1'b0, 1'b0);
    tick();
    check_out("sab_b2", 8'h0A, 1'b1, 1'b0);
    tick();
    check_eq("sab_done_valid", out_valid, 1'b0);

    // SPLIT with backpressure on byte 1 and a competing word
    accept("s12", 20'h12345, 1'b1);
    check_out("s12_b0", 8'h45, 1'b0, 1'b0);
    tick();
    check_out("s12_b1", 8'h23, 1'b0, 1'b0);
    out_ready = 1'b0;
    in_word   = 20'hFFFFF;
    in_mode   = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_out("s12_hold", 8'h23, 1'b0, 1'b0);
      check_eq("s12_hold_in_ready", in_ready, 1'b0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    check_out("s12_b2", 8'h01, 1'b1, 1'b0);
    check_eq("s12_count", ovf_count, 8'd1);
    tick();
    check_eq("s12_done_valid", out_valid, 1'b0);

    // Reset in the middle of a SPLIT word
    accept("srst", 20'hABCDE, 1'b1);
    tick();
    check_out("srst_b1", 8'hBC, 1'b0, 1'b0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check_eq("srst_valid", out_valid, 1'b0);
    check_eq("srst_in_ready", in_ready, 1'b1);
    check_eq("srst_count", ovf_count, 8'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("srst_no_tail", out_valid, 1'b0);
    end

    // Overflow counter saturation
    for (int i = 0; i < 260; i++) begin
      accept("sat", 20'h10000, 1'b0);
      check_out("sat", 8'h00, 1'b1, 1'b1);
      check_eq("sat_count", ovf_count, (i + 1 > 255) ? 32'd255 : 32'(i + 1));
      tick();
    end
    check_eq("sat_final", ovf_count, 8'd255);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
